switch_port_arbiter: RTL and testbench

- Grants the 4-port switch's output ports to its input ports on a per-packet basis.
- Single, multicast and broadcast packets receive all their target outputs atomically.
- Rotating priority plus head-of-line reservation prevents starvation; a watchdog releases packets with no end of packet.
- Sits between the per-port input queues and the output crossbar; per-output `suspend_ip` comes from `port_if`.

---
 rtl/switch_arb_pkg.sv | 33 +++
 rtl/switch_arb_src.sv | 92 +++++++++
 rtl/switch_port_arbiter.sv | 99 +++++++++
 tb/tb_switch_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/switch_arb_pkg.sv
// Shared types and the effective-target-mask helper for the 4-port switch arbiter.
package switch_arb_pkg;

    localparam int NPORTS = 4;

    typedef logic [3:0] port_mask_t;

    localparam port_mask_t BCAST_MASK = 4'hF;

    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} src_state_e;

    typedef struct packed {
        logic       legal;
        port_mask_t mask;
    } eff_mask_t;

    // Broadcast means "every output except my own"; any other mask must be
    // nonzero and must not loop back to the source port.
    function automatic eff_mask_t eff_mask(input logic [1:0] src, input port_mask_t target);
        eff_mask_t  r;
        port_mask_t self;
        self = port_mask_t'(4'b0001 << src);
        if (target == BCAST_MASK) begin
            r.mask  = BCAST_MASK & ~self;
            r.legal = 1'b1;
        end else begin
            r.mask  = target;
            r.legal = (target != '0) && ((target & self) == '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_arb_src.sv
// Per-source request FSM with a watchdog that forcibly ends packets lacking eop.
module switch_arb_src #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic legal_i,
    input  logic eop_i,
    input  logic grant_i,
    output logic wait_o,
    output logic active_o,
    output logic release_o,
    output logic illegal_err_o,
    output logic timeout_err_o
);
    import switch_arb_pkg::*;

    src_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       blocked_q, blocked_d;
    logic       ill_q, ill_d;
    logic       to_q, to_d;
    logic       expire;

    assign expire        = (cnt_q == 8'(TIMEOUT - 1));
    // Requests that drop in the same cycle are never offered for arbitration.
    assign wait_o        = (state_q == WAIT) && req_i;
    assign active_o      = (state_q == ACTIVE);
    assign release_o     = active_o && (eop_i || expire);
    assign illegal_err_o = ill_q;
    assign timeout_err_o = to_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blocked_d = blocked_q && req_i;
        ill_d     = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // An illegal request is reported once and ignored until req drops.
                if (req_i && !blocked_q) begin
                    if (legal_i) begin
                        state_d = WAIT;
                    end else begin
                        ill_d     = 1'b1;
                        blocked_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (grant_i) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (eop_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
            ill_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            ill_q     <= ill_d;
            to_q      <= to_d;
        end
    end

endmodule

// File: rtl/switch_port_arbiter.sv
// Per-packet output-port arbiter: rotating priority with head-of-line reservation,
// atomic multi-output grants, and registered output ownership.
module switch_port_arbiter #(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORTS-1:0]   req,
    input  logic [4*NPORTS-1:0] req_target,
    input  logic [NPORTS-1:0]   eop,
    input  logic [NPORTS-1:0]   suspend,
    output logic [NPORTS-1:0]   gnt,
    output logic [4*NPORTS-1:0] out_sel,
    output logic [NPORTS-1:0]   out_busy,
    output logic [NPORTS-1:0]   illegal_err,
    output logic [NPORTS-1:0]   timeout_err
);
    import switch_arb_pkg::*;

    port_mask_t [3:0] mask;
    logic       [3:0] legal, waiting, rel, grant;
    port_mask_t [3:0] sel_q, sel_d;
    port_mask_t       busy_q, busy_d;
    port_mask_t       taken, resv;
    logic       [1:0] rr_ptr_q, rr_ptr_d;
    logic       [1:0] s;

    for (genvar i = 0; i < 4; i++) begin : g_src
        eff_mask_t em;
        assign em       = eff_mask(2'(i), req_target[4*i +: 4]);
        assign mask[i]  = em.mask;
        assign legal[i] = em.legal;

        switch_arb_src #(.TIMEOUT(TIMEOUT)) u_src (
            .clk          (clk),
            .reset        (reset),
            .req_i        (req[i]),
            .legal_i      (legal[i]),
            .eop_i        (eop[i]),
            .grant_i      (grant[i]),
            .wait_o       (waiting[i]),
            .active_o     (gnt[i]),
            .release_o    (rel[i]),
            .illegal_err_o(illegal_err[i]),
            .timeout_err_o(timeout_err[i])
        );
    end

    // Walk sources from rr_ptr; the head source, if blocked, reserves its outputs
    // so later sources cannot keep nibbling at a multicast packet's targets.
    always_comb begin
        grant    = '0;
        taken    = '0;
        resv     = '0;
        s        = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            s = rr_ptr_q + 2'(k);
            if (waiting[s]) begin
                if ((mask[s] & (busy_q | suspend | taken | resv)) == '0) begin
                    grant[s] = 1'b1;
                    taken    = taken | mask[s];
                    rr_ptr_d = s + 2'd1;
                end else if (k == 0) begin
                    resv = mask[s];
                end
            end
        end
    end

    always_comb begin
        sel_d  = sel_q;
        busy_d = '0;
        for (int j = 0; j < 4; j++) begin
            if ((sel_q[j] & rel) != '0) sel_d[j] = '0;
            for (int i = 0; i < 4; i++) begin
                if (grant[i] && mask[i][j]) sel_d[j] = port_mask_t'(4'b0001 << i);
            end
            busy_d[j] = |sel_d[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q    <= '0;
            busy_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_sel  = sel_q;
    assign out_busy = busy_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed bench: cycle-by-cycle vector table plus hand-written watchdog/reset sequences.
module tb_switch_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, eop, suspend;
    logic [15:0] req_target;
    logic [3:0]  gnt, out_busy, illegal_err, timeout_err;
    logic [15:0] out_sel;

    int n_chk  = 0;
    int n_fail = 0;

    switch_port_arbiter #(.NPORTS(4), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_target (req_target),
        .eop        (eop),
        .suspend    (suspend),
        .gnt        (gnt),
        .out_sel    (out_sel),
        .out_busy   (out_busy),
        .illegal_err(illegal_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] tgt;
        logic [3:0]  eop;
        logic [3:0]  sus;
        logic [3:0]  gnt;
        logic [15:0] sel;
        logic [3:0]  busy;
        logic [3:0]  ill;
        logic [3:0]  to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic [3:0] rq, logic [15:0] tg, logic [3:0] ep, logic [3:0] sp,
                               logic [3:0] g, logic [15:0] sl, logic [3:0] b,
                               logic [3:0] il, logic [3:0] tt);
        vec_t r;
        r.req = rq; r.tgt = tg; r.eop = ep; r.sus = sp;
        r.gnt = g;  r.sel = sl; r.busy = b; r.ill = il; r.to = tt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [15:0] sl,
                           input logic [3:0] b, input logic [3:0] il, input logic [3:0] tt);
        chk({tag, ".gnt"},  {12'h0, gnt},         {12'h0, g});
        chk({tag, ".sel"},  out_sel,              sl);
        chk({tag, ".busy"}, {12'h0, out_busy},    {12'h0, b});
        chk({tag, ".ill"},  {12'h0, illegal_err}, {12'h0, il});
        chk({tag, ".to"},   {12'h0, timeout_err}, {12'h0, tt});
    endtask

    task automatic drive(input logic [3:0] rq, input logic [15:0] tg,
                         input logic [3:0] ep, input logic [3:0] sp);
        req = rq; req_target = tg; eop = ep; suspend = sp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Concurrent singles: src0->out1, src2->out3; one-beat packets
        vecs.push_back(v(4'h5, 16'h0802, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h5, 16'h0802, 4'h0, 4'h0, 4'h5, 16'h4010, 4'hA, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0802, 4'h5, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        // src3->out0 and src0->out1 together (rr ends at 1), then broadcast from src1
        vecs.push_back(v(4'h9, 16'h1002, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h9, 16'h1002, 4'h0, 4'h0, 4'h9, 16'h0018, 4'h3, 4'h0, 4'h0));
        vecs.push_back(v(4'h2, 16'h00F0, 4'h1, 4'h0, 4'h8, 16'h0008, 4'h1, 4'h0, 4'h0));
        vecs.push_back(v(4'h3, 16'h00F4, 4'h0, 4'h0, 4'h8, 16'h0008, 4'h1, 4'h0, 4'h0));
        vecs.push_back(v(4'h3, 16'h00F4, 4'h8, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h3, 16'h00F4, 4'h0, 4'h0, 4'h2, 16'h2202, 4'hD, 4'h0, 4'h0));
        vecs.push_back(v(4'h1, 16'h00F4, 4'h2, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h1, 16'h0004, 4'h0, 4'h0, 4'h1, 16'h0100, 4'h4, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0004, 4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        // Illegal: src2 targets itself, then an empty mask
        vecs.push_back(v(4'h4, 16'h0400, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h4, 4'h0));
        vecs.push_back(v(4'h4, 16'h0400, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h4, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h4, 4'h0));
        vecs.push_back(v(4'h4, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        // Suspend on out1 holds off src0, then fails to preempt it
        vecs.push_back(v(4'h1, 16'h0002, 4'h0, 4'h2, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h1, 16'h0002, 4'h0, 4'h2, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h1, 16'h0002, 4'h0, 4'h2, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h1, 16'h0002, 4'h0, 4'h0, 4'h1, 16'h0010, 4'h2, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0002, 4'h0, 4'h2, 4'h1, 16'h0010, 4'h2, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0002, 4'h1, 4'h2, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));
        vecs.push_back(v(4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0));

        reset = 1'b0;
        drive(4'h0, 16'h0, 4'h0, 4'h0);
        #12;
        chk_all("reset", 4'h0, 16'h0, 4'h0, 4'h0, 4'h0);
        reset = 1'b1;
        tick();

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].req, vecs[n].tgt, vecs[n].eop, vecs[n].sus);
            tick();
            chk_all($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].sel, vecs[n].busy,
                    vecs[n].ill, vecs[n].to);
        end

        // Watchdog: src3 on out0 never sends eop; TIMEOUT=4
        drive(4'h8, 16'h1000, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("wd.grant", 4'h8, 16'h0008, 4'h1, 4'h0, 4'h0);
        drive(4'h0, 16'h1000, 4'h0, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_all($sformatf("wd.hold%0d", k), 4'h8, 16'h0008, 4'h1, 4'h0, 4'h0);
        end
        tick();
        chk_all("wd.expire", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h8);
        tick();
        chk_all("wd.after", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);

        // eop landing on the expiry cycle ends the packet cleanly
        drive(4'h8, 16'h1000, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("wde.grant", 4'h8, 16'h0008, 4'h1, 4'h0, 4'h0);
        drive(4'h0, 16'h1000, 4'h0, 4'h0);
        tick();
        tick();
        tick();
        drive(4'h0, 16'h1000, 4'h8, 4'h0);
        tick();
        chk_all("wde.eop", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
        drive(4'h0, 16'h0, 4'h0, 4'h0);
        tick();
        chk_all("wde.after", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Reset in the middle of a packet clears outputs without a clock edge
        drive(4'h1, 16'h0002, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("rst.pre", 4'h1, 16'h0010, 4'h2, 4'h0, 4'h0);
        drive(4'h0, 16'h0, 4'h0, 4'h0);
        #2 reset = 1'b0;
        #1;
        chk_all("rst.async", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
        #2 reset = 1'b1;

        // After reset rr_ptr is 0: src0 and src3 first, then src1, then src2 on out3
        drive(4'hF, 16'h1888, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("rot.s0s3", 4'h9, 16'h1008, 4'h9, 4'h0, 4'h0);
        drive(4'h6, 16'h1888, 4'h9, 4'h0);
        tick();
        chk_all("rot.rel0", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
        drive(4'h6, 16'h1888, 4'h0, 4'h0);
        tick();
        chk_all("rot.s1", 4'h2, 16'h2000, 4'h8, 4'h0, 4'h0);
        drive(4'h4, 16'h1888, 4'h2, 4'h0);
        tick();
        chk_all("rot.rel1", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
        drive(4'h4, 16'h1888, 4'h0, 4'h0);
        tick();
        chk_all("rot.s2", 4'h4, 16'h4000, 4'h8, 4'h0, 4'h0);
        drive(4'h0, 16'h0, 4'h4, 4'h0);
        tick();
        chk_all("rot.rel2", 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
